// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner: rotates one low column strobe, samples the rows once per slot,
// and debounces whole-scan results into a single accepted key with press/held/release signalling.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1350,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rows_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       key_release
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;

    logic [3:0]       rows_meta, rows_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx, col_next;
    logic             tick, scan_end;
    logic [1:0]       acc_hits;
    logic [3:0]       acc_code;
    logic [1:0]       col_hits, row_sel, tot_hits;
    logic [2:0]       hit_sum;
    logic [3:0]       hit_code;
    logic             is_none, is_single;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx, cand, cand_nx, code_nx;
    logic       valid_nx, release_nx, held_nx;

    assign tick     = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign scan_end = tick && (col_idx == 2'd3);
    assign col_next = col_idx + 2'd1;

    // Hits in the current column merged with the rest of the scan, saturating at 2.
    always_comb begin
        col_hits = 2'd0;
        row_sel  = 2'd0;
        for (int r = 0; r < 4; r++) begin
            if (!rows_sync[r]) begin
                row_sel = 2'(r);
                if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
            end
        end
        hit_sum   = {1'b0, acc_hits} + {1'b0, col_hits};
        tot_hits  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        hit_code  = (col_hits != 2'd0) ? {col_idx, row_sel} : acc_code;
        is_none   = (tot_hits == 2'd0);
        is_single = (tot_hits == 2'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rows_meta <= 4'hF;
            rows_sync <= 4'hF;
            div_cnt   <= '0;
            col_idx   <= 2'd0;
            col_n     <= 4'b1110;
            acc_hits  <= 2'd0;
            acc_code  <= 4'd0;
        end else begin
            rows_meta <= rows_n;
            rows_sync <= rows_meta;
            div_cnt   <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                col_idx <= col_next;
                col_n   <= ~(4'b0001 << col_next);
                if (scan_end) begin
                    acc_hits <= 2'd0;
                    acc_code <= 4'd0;
                end else begin
                    acc_hits <= tot_hits;
                    acc_code <= hit_code;
                end
            end
        end
    end

    // Debounce FSM advances only on complete scan results.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        cand_nx    = cand;
        code_nx    = key_code;
        valid_nx   = 1'b0;
        release_nx = 1'b0;
        if (scan_end) begin
            case (state)
                IDLE: begin
                    if (is_single) begin
                        state_nx = CAND;
                        cand_nx  = hit_code;
                        cnt_nx   = 4'd1;
                    end
                end
                CAND: begin
                    if (is_single && hit_code == cand) begin
                        if (cnt + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
                            state_nx = PRESSED;
                            code_nx  = cand;
                            valid_nx = 1'b1;
                        end else begin
                            cnt_nx = cnt + 4'd1;
                        end
                    end else if (is_single) begin
                        cand_nx = hit_code;
                        cnt_nx  = 4'd1;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                PRESSED: begin
                    if (is_none) begin
                        state_nx = REL;
                        cnt_nx   = 4'd1;
                    end
                end
                REL: begin
                    if (is_none) begin
                        if (cnt + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
                            state_nx   = IDLE;
                            release_nx = 1'b1;
                        end else begin
                            cnt_nx = cnt + 4'd1;
                        end
                    end else begin
                        state_nx = PRESSED;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        held_nx = (state_nx == PRESSED) || (state_nx == REL);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            cand        <= 4'd0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            cand        <= cand_nx;
            key_code    <= code_nx;
            key_valid   <= valid_nx;
            key_held    <= held_nx;
            key_release <= release_nx;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized scan-level stimulus for keypad_scanner, checked against a run-length
// model of debounced press/release acceptance.
module tb_keypad_scanner;
    localparam int SD   = 4;
    localparam int DB   = 3;
    localparam int SCAN = 4 * SD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  rows_n, col_n, key_code;
    logic        key_valid, key_held, key_release;
    logic [15:0] keys = 16'h0;

    int n_assert = 0;
    int n_fail   = 0;

    // Scan-level reference state
    bit         m_held = 1'b0;
    logic [3:0] m_code = 4'd0;
    int         run_len = 0, run_code = -1, none_run = 0;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
        .clk(clk), .rst_n(rst_n), .rows_n(rows_n), .col_n(col_n),
        .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .key_release(key_release)
    );

    always #5 clk = ~clk;

    // Key (c,r) shorts column c to row r; bit index of keys is 4*c+r.
    always_comb begin
        rows_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*c+r] && !col_n[c]) rows_n[r] = 1'b0;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_col_n", col_n, 4'b1110);
            chk("rst_key_code", key_code, 4'd0);
            chk("rst_key_valid", {3'b0, key_valid}, 4'd0);
            chk("rst_key_held", {3'b0, key_held}, 4'd0);
            chk("rst_key_release", {3'b0, key_release}, 4'd0);
        end
        rst_n   = 1'b1;
        m_held  = 1'b0;
        m_code  = 4'd0;
        run_len = 0; run_code = -1; none_run = 0;
    endtask

    // One full scan with a fixed set of pressed keys; outputs checked every cycle.
    task automatic do_scan(input logic [15:0] m);
        int         nh;
        int         kc;
        bit         prev_held, exp_v, exp_r;
        logic [3:0] prev_code, exp_col;
        keys = m;
        nh = 0; kc = 0;
        for (int i = 0; i < 16; i++) if (m[i]) begin nh++; kc = i; end
        prev_held = m_held;
        prev_code = m_code;
        exp_v = 1'b0; exp_r = 1'b0;
        if (nh == 1) begin
            if (run_code == kc) run_len++;
            else begin run_code = kc; run_len = 1; end
            none_run = 0;
        end else if (nh == 0) begin
            none_run++; run_len = 0; run_code = -1;
        end else begin
            none_run = 0; run_len = 0; run_code = -1;
        end
        if (!m_held && nh == 1 && run_len == DB) begin
            m_held = 1'b1; exp_v = 1'b1; m_code = 4'(kc);
        end else if (m_held && nh == 0 && none_run == DB) begin
            m_held = 1'b0; exp_r = 1'b1;
        end
        for (int i = 1; i <= SCAN; i++) begin
            @(posedge clk); #1;
            exp_col = 4'b0001 << ((i % SCAN) / SD);
            chk("col_n", col_n, ~exp_col);
            if (i < SCAN) begin
                chk("key_valid_idle", {3'b0, key_valid}, 4'd0);
                chk("key_release_idle", {3'b0, key_release}, 4'd0);
                chk("key_held_mid", {3'b0, key_held}, {3'b0, prev_held});
                chk("key_code_mid", key_code, prev_code);
            end else begin
                chk("key_valid", {3'b0, key_valid}, {3'b0, exp_v});
                chk("key_release", {3'b0, key_release}, {3'b0, exp_r});
                chk("key_held", {3'b0, key_held}, {3'b0, m_held});
                chk("key_code", key_code, m_code);
            end
        end
    endtask

    initial begin
        logic [15:0] m;
        do_reset();

        // Clean press of (2,1) = code 9, then release
        repeat (6) do_scan(16'h1 << 9);
        repeat (4) do_scan(16'h0);

        // Bouncy press of (1,3) = code 7 never reaches acceptance
        repeat (2) do_scan(16'h1 << 7);
        do_scan(16'h0);
        repeat (2) do_scan(16'h1 << 7);
        repeat (2) do_scan(16'h0);

        // (0,0)+(1,1) is MULTI; dropping (1,1) leaves code 0
        repeat (6) do_scan(16'h0021);
        repeat (3) do_scan(16'h0001);
        repeat (4) do_scan(16'h0);

        // Release bounce on key 5
        repeat (3) do_scan(16'h1 << 5);
        do_scan(16'h0);
        do_scan(16'h1 << 5);
        repeat (3) do_scan(16'h0);

        // Reset while key 9 is held, key still down afterwards
        repeat (4) do_scan(16'h1 << 9);
        do_reset();
        repeat (3) do_scan(16'h1 << 9);
        repeat (3) do_scan(16'h0);

        // Randomized scans with a bias toward repeating the previous pattern
        m = 16'h0;
        for (int s = 0; s < 150; s++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: ;
                6, 7: m = 16'h0;
                8: begin m = 16'h0; m[$urandom_range(0, 15)] = 1'b1; end
                default: begin
                    m = 16'h0;
                    m[$urandom_range(0, 15)] = 1'b1;
                    m[$urandom_range(0, 15)] = 1'b1;
                end
            endcase
            do_scan(m);
        end
        repeat (3) do_scan(16'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
